sya_pe_bank_os: RTL and testbench

//  Output-stationary systolic PE bank, NUM_ROW x NUM_COL. Runs one tile: cfg_k activation/weight beats, internally skewed.

---
 rtl/sya_pkg.sv | 21 ++
 rtl/sya_pe.sv | 47 ++++
 rtl/sya_pe_bank_os.sv | 195 +++++++++++++++++++
 tb/tb_sya_pe_bank_os.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sya_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic PE bank.
package sya_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w = 1;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

  function automatic int unsigned flush_len(input int unsigned nr, input int unsigned nc);
    return nr + nc - 2;
  endfunction

  function automatic int unsigned quant_width(input int unsigned pw, input int unsigned qw);
    return pw + qw + 1;
  endfunction

endpackage

// File: rtl/sya_pe.sv
// Single output-stationary MAC PE: accumulates act*wgt on step and forwards both operands.
module sya_pe #(
  parameter int unsigned ACT_WIDTH  = 8,
  parameter int unsigned WGT_WIDTH  = 8,
  parameter int unsigned PSUM_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic                  clr,
  input  logic [ACT_WIDTH-1:0]  act_in,
  input  logic [WGT_WIDTH-1:0]  wgt_in,
  output logic [ACT_WIDTH-1:0]  act_out,
  output logic [WGT_WIDTH-1:0]  wgt_out,
  output logic [PSUM_WIDTH-1:0] acc
);

  localparam int unsigned PW = ACT_WIDTH + WGT_WIDTH;

  logic signed [PW-1:0] prod;
  logic [PSUM_WIDTH-1:0] acc_q;
  logic [ACT_WIDTH-1:0]  act_q;
  logic [WGT_WIDTH-1:0]  wgt_q;

  assign prod = $signed(act_in) * $signed(wgt_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      act_q <= '0;
      wgt_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      act_q <= '0;
      wgt_q <= '0;
    end else if (step) begin
      acc_q <= acc_q + {{(PSUM_WIDTH - PW){prod[PW-1]}}, prod};
      act_q <= act_in;
      wgt_q <= wgt_in;
    end
  end

  assign acc     = acc_q;
  assign act_out = act_q;
  assign wgt_out = wgt_q;

endmodule

// File: rtl/sya_pe_bank_os.sv
// Output-stationary NUM_ROW x NUM_COL PE bank with input skew, flush and per-row requant drain.
module sya_pe_bank_os
  import sya_pkg::*;
#(
  parameter int unsigned NUM_ROW    = 16,
  parameter int unsigned NUM_COL    = 16,
  parameter int unsigned ACT_WIDTH  = 8,
  parameter int unsigned WGT_WIDTH  = 8,
  parameter int unsigned K_WIDTH    = 10,
  parameter int unsigned PSUM_WIDTH = ACT_WIDTH + WGT_WIDTH + K_WIDTH,
  parameter int unsigned QNT_WIDTH  = 20,
  parameter int unsigned FM_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [K_WIDTH-1:0]            cfg_k,
  input  logic [QNT_WIDTH-1:0]          cfg_scale,
  input  logic [5:0]                    cfg_shift,
  input  logic [FM_WIDTH-1:0]           cfg_zero_point,
  input  logic                          cfg_relu,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [ACT_WIDTH*NUM_ROW-1:0]  in_act,
  input  logic [WGT_WIDTH*NUM_COL-1:0]  in_wgt,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [FM_WIDTH*NUM_COL-1:0]   out_fm,
  output logic [clog2(NUM_ROW)-1:0]     out_row_idx
);

  localparam int unsigned RW = clog2(NUM_ROW);
  localparam int unsigned FL = flush_len(NUM_ROW, NUM_COL);
  localparam int unsigned FW = clog2(FL);
  localparam int unsigned QW = quant_width(PSUM_WIDTH, QNT_WIDTH);
  localparam logic signed [QW:0] FmMax = {{(QW + 1 - FM_WIDTH){1'b0}}, {FM_WIDTH{1'b1}}};

  state_e state_q, state_d;
  logic step, clr, flushing, last_hs, load_en;
  logic [K_WIDTH-1:0] cfg_k_q, beat_cnt_q;
  logic [FW-1:0]      flush_cnt_q;
  logic [RW-1:0]      load_row;
  logic [FM_WIDTH*NUM_COL-1:0] fm_row;

  logic [ACT_WIDTH-1:0]  act_h [NUM_ROW][NUM_COL+1];
  logic [WGT_WIDTH-1:0]  wgt_v [NUM_ROW+1][NUM_COL];
  logic [PSUM_WIDTH-1:0] acc   [NUM_ROW][NUM_COL];
  logic [NUM_ROW-1:0]    unused_act_edge;
  logic [NUM_COL-1:0]    unused_wgt_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (cfg_k == '0) ? StFlush : StLoad;
      StLoad:  if (in_vld && beat_cnt_q == cfg_k_q - K_WIDTH'(1)) state_d = StFlush;
      StFlush: if (flush_cnt_q == FW'(FL - 1)) state_d = StDrain;
      StDrain: if (last_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q != StIdle);
    in_rdy   = (state_q == StLoad);
    flushing = (state_q == StFlush);
    step     = (in_rdy && in_vld) || flushing;
    clr      = (state_q == StIdle) && start;
    last_hs  = (state_q == StDrain) && out_vld && out_rdy && (out_row_idx == RW'(NUM_ROW - 1));
    load_en  = (state_q == StDrain) &&
               (!out_vld || (out_rdy && out_row_idx != RW'(NUM_ROW - 1)));
    load_row = out_vld ? out_row_idx + RW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_k_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (clr) begin
        cfg_k_q    <= cfg_k;
        beat_cnt_q <= '0;
      end else if (in_rdy && in_vld) begin
        beat_cnt_q <= beat_cnt_q + K_WIDTH'(1);
      end
      flush_cnt_q <= flushing ? flush_cnt_q + FW'(1) : '0;
    end
  end

  // Row r activations are delayed r steps so beat t meets PE(r,c) on step t+r+c.
  for (genvar r = 0; r < NUM_ROW; r++) begin : g_act_skew
    logic [ACT_WIDTH-1:0] src;
    assign src = flushing ? '0 : in_act[r*ACT_WIDTH +: ACT_WIDTH];
    if (r == 0) begin : g_direct
      assign act_h[r][0] = src;
    end else begin : g_delay
      logic [ACT_WIDTH-1:0] sr [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (step) begin
          sr[0] <= src;
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign act_h[r][0] = sr[r-1];
    end
    assign unused_act_edge[r] = ^act_h[r][NUM_COL];
  end

  for (genvar c = 0; c < NUM_COL; c++) begin : g_wgt_skew
    logic [WGT_WIDTH-1:0] src;
    assign src = flushing ? '0 : in_wgt[c*WGT_WIDTH +: WGT_WIDTH];
    if (c == 0) begin : g_direct
      assign wgt_v[0][c] = src;
    end else begin : g_delay
      logic [WGT_WIDTH-1:0] sr [c];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else if (step) begin
          sr[0] <= src;
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign wgt_v[0][c] = sr[c-1];
    end
    assign unused_wgt_edge[c] = ^wgt_v[NUM_ROW][c];
  end

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      sya_pe #(
        .ACT_WIDTH  (ACT_WIDTH),
        .WGT_WIDTH  (WGT_WIDTH),
        .PSUM_WIDTH (PSUM_WIDTH)
      ) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (step),
        .clr     (clr),
        .act_in  (act_h[r][c]),
        .wgt_in  (wgt_v[r][c]),
        .act_out (act_h[r][c+1]),
        .wgt_out (wgt_v[r+1][c]),
        .acc     (acc[r][c])
      );
    end
  end

  // Requantise the row about to be loaded: signed acc x unsigned scale, round half up, clamp.
  for (genvar c = 0; c < NUM_COL; c++) begin : g_quant
    logic [PSUM_WIDTH-1:0] a;
    logic signed [QW-1:0]  acc_x, scl_x, prod, rnd, q;
    logic signed [QW:0]    q_x, zp_x, y, lo;
    assign a     = acc[load_row][c];
    assign acc_x = {{(QW - PSUM_WIDTH){a[PSUM_WIDTH-1]}}, a};
    assign scl_x = {{(QW - QNT_WIDTH){1'b0}}, cfg_scale};
    assign prod  = acc_x * scl_x;
    assign rnd   = (cfg_shift == 6'd0) ? '0 : (QW'(1) << (cfg_shift - 6'd1));
    assign q     = (prod + rnd) >>> cfg_shift;
    assign q_x   = {q[QW-1], q};
    assign zp_x  = {{(QW + 1 - FM_WIDTH){1'b0}}, cfg_zero_point};
    assign y     = q_x + zp_x;
    assign lo    = cfg_relu ? zp_x : '0;
    assign fm_row[c*FM_WIDTH +: FM_WIDTH] = (y < lo)    ? (cfg_relu ? cfg_zero_point : '0) :
                                            (y > FmMax) ? '1 : y[FM_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_fm      <= '0;
      out_row_idx <= '0;
      out_vld     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= last_hs;
      if (load_en) begin
        out_fm      <= fm_row;
        out_row_idx <= load_row;
        out_vld     <= 1'b1;
      end else if (last_hs) begin
        out_vld     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sya_pe_bank_os.sv
// Directed table-driven bench for a 4x4 sya_pe_bank_os, plus reset and back-to-back sequences.
module tb_sya_pe_bank_os;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int KW = 10;
  localparam int QNW = 20;
  localparam int NV = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [KW-1:0] cfg_k = '0;
  logic [QNW-1:0] cfg_scale = '0;
  logic [5:0] cfg_shift = '0;
  logic [7:0] cfg_zero_point = '0;
  logic cfg_relu = 1'b0;
  logic busy, done, in_rdy, out_vld;
  logic in_vld = 1'b0;
  logic out_rdy = 1'b1;
  logic [8*NR-1:0] in_act = '0;
  logic [8*NC-1:0] in_wgt = '0;
  logic [8*NC-1:0] out_fm;
  logic [1:0] out_row_idx;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int k; int ident; int act; int wgt; int scale; int shift; int zp; int relu;
    int in_stall; int out_stall; int poke; int b2b; int diag; int off;
  } vec_t;

  vec_t vecs[NV];

  sya_pe_bank_os #(
    .NUM_ROW   (NR),
    .NUM_COL   (NC),
    .ACT_WIDTH (8),
    .WGT_WIDTH (8),
    .K_WIDTH   (KW),
    .QNT_WIDTH (QNW),
    .FM_WIDTH  (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_k          (cfg_k),
    .cfg_scale      (cfg_scale),
    .cfg_shift      (cfg_shift),
    .cfg_zero_point (cfg_zero_point),
    .cfg_relu       (cfg_relu),
    .busy           (busy),
    .done           (done),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .in_act         (in_act),
    .in_wgt         (in_wgt),
    .out_vld        (out_vld),
    .out_rdy        (out_rdy),
    .out_fm         (out_fm),
    .out_row_idx    (out_row_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_row(input vec_t v, input int r);
    logic [31:0] row;
    int val;
    for (int c = 0; c < NC; c++) begin
      val = (v.ident != 0 && r != c) ? v.off : v.diag;
      row[c*8 +: 8] = val[7:0];
    end
    return row;
  endfunction

  task automatic drive_beat(input vec_t v, input int t);
    for (int r = 0; r < NR; r++)
      in_act[r*8 +: 8] = (v.ident != 0) ? ((r == t) ? 8'd1 : 8'd0) : v.act[7:0];
    for (int c = 0; c < NC; c++)
      in_wgt[c*8 +: 8] = (v.ident != 0) ? ((c == t) ? 8'd1 : 8'd0) : v.wgt[7:0];
  endtask

  task automatic set_cfg(input vec_t v);
    cfg_k          = v.k[KW-1:0];
    cfg_scale      = v.scale[QNW-1:0];
    cfg_shift      = v.shift[5:0];
    cfg_zero_point = v.zp[7:0];
    cfg_relu       = v.relu[0];
  endtask

  // Entered and left at a negedge; returns in the cycle where done should be high.
  task automatic run_tile(input vec_t v, input string tag);
    int beat, budget, got, stall_left, e0;
    bit seen_rdy, prev_hold, rdy, vv, rd, first_seen, poked;
    logic [31:0] prev_fm;
    logic [1:0] prev_idx;
    set_cfg(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = cyc;
    beat = 0; budget = 6000; seen_rdy = 0;
    while (beat < v.k && budget > 0) begin
      rdy = in_rdy;
      seen_rdy |= rdy;
      vv = (v.in_stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_vld = vv;
      drive_beat(v, beat);
      tick();
      budget--;
      if (rdy && vv) begin
        beat++;
        e0 = cyc;
      end
    end
    in_vld = 1'b0; in_act = '0; in_wgt = '0;
    if (beat < v.k) chk({tag, " beats accepted"}, 64'(beat), 64'(v.k));
    if (v.poke != 0) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    got = 0; budget = 200; stall_left = 0; prev_hold = 0; first_seen = 0; poked = 0;
    prev_fm = '0; prev_idx = '0;
    while (got < NR && budget > 0) begin
      seen_rdy |= in_rdy;
      rd = (stall_left == 0);
      if (out_vld) begin
        if (!first_seen) begin
          first_seen = 1;
          chk({tag, " latency"}, 64'(cyc), 64'(e0 + NR + NC - 1));
        end
        if (prev_hold) begin
          chk({tag, " hold fm"}, 64'(out_fm), 64'(prev_fm));
          chk({tag, " hold idx"}, 64'(out_row_idx), 64'(prev_idx));
        end
        if (v.poke != 0 && !poked) begin
          start = 1'b1;
          poked = 1;
        end
      end
      out_rdy = rd;
      if (out_vld && rd) begin
        chk($sformatf("%s row%0d idx", tag, got), 64'(out_row_idx), 64'(got));
        chk($sformatf("%s row%0d fm", tag, got), 64'(out_fm), 64'(exp_row(v, got)));
        got++;
        if (v.out_stall != 0 && got == 1) stall_left = 3;
      end else if (!rd) begin
        stall_left--;
      end
      prev_hold = out_vld && !rd;
      prev_fm = out_fm;
      prev_idx = out_row_idx;
      tick();
      start = 1'b0;
      budget--;
    end
    out_rdy = 1'b1;
    if (got < NR) chk({tag, " rows received"}, 64'(got), 64'(NR));
    chk({tag, " done pulse"}, 64'(done), 64'd1);
    chk({tag, " busy after"}, 64'(busy), 64'd0);
    if (v.k == 0) chk({tag, " in_rdy seen"}, 64'(seen_rdy), 64'd0);
  endtask

  initial begin
    //        k   id act  wgt sc sh  zp rl ist ost pk b2b diag off
    vecs[0]  = '{4,    1, 0,    0,  1, 0,  0,   0, 0, 0, 0, 0, 1,   0};
    vecs[1]  = '{4,    1, 0,    0,  1, 0,  0,   0, 1, 1, 0, 0, 1,   0};
    vecs[2]  = '{10,   0, 3,   -5,  3, 2,  200, 0, 0, 0, 0, 0, 88,  88};
    vecs[3]  = '{5,    0, 100, 100, 1, 4,  0,   0, 0, 0, 0, 0, 255, 255};
    vecs[4]  = '{1023, 0, -128, 127, 1, 16, 128, 0, 0, 0, 0, 0, 0,   0};
    vecs[5]  = '{1023, 0, -128, 127, 1, 16, 128, 1, 0, 0, 0, 0, 128, 128};
    vecs[6]  = '{3,    0, -1,  -1,  1, 1,  128, 0, 0, 0, 0, 0, 130, 130};
    vecs[7]  = '{3,    0, -1,   1,  1, 1,  10,  0, 0, 0, 0, 0, 9,   9};
    vecs[8]  = '{0,    0, 0,    0,  1, 0,  7,   0, 0, 0, 0, 0, 7,   7};
    vecs[9]  = '{4,    1, 0,    0,  1, 0,  0,   0, 0, 0, 1, 0, 1,   0};
    vecs[10] = '{4,    1, 0,    0,  1, 0,  0,   0, 0, 0, 0, 1, 1,   0};
    vecs[11] = '{4,    0, 2,    3,  5, 3,  1,   0, 0, 0, 0, 1, 16,  16};

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset in_rdy", 64'(in_rdy), 64'd0);
    chk("reset out_vld", 64'(out_vld), 64'd0);
    chk("reset out_fm", 64'(out_fm), 64'd0);
    chk("reset out_row_idx", 64'(out_row_idx), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < NV; i++) begin
      run_tile(vecs[i], $sformatf("v%0d", i));
      if (!(i < NV - 1 && vecs[i+1].b2b != 0)) begin
        tick();
        chk($sformatf("v%0d done width", i), 64'(done), 64'd0);
        tick();
      end
    end

    // Abort a tile after two beats with an asynchronous reset, then rerun it cleanly.
    set_cfg(vecs[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      in_vld = 1'b1;
      drive_beat(vecs[0], t);
      tick();
    end
    in_vld = 1'b0; in_act = '0; in_wgt = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset in_rdy", 64'(in_rdy), 64'd0);
    chk("midreset out_vld", 64'(out_vld), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_tile(vecs[0], "after reset");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
